// File: rtl/tsc_cycle_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the TSC CPU datapath.
// Optional TSC_INST_COUNT_EN adds a retired-instruction counter port num_inst.
module tsc_cycle_sequencer #(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cpu_enable,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       inst,
  output logic [15:0]       pc,
  output logic              rf_we,
  output logic [1:0]        rf_waddr,
  output logic              alu_src,
  output logic [1:0]        imm_mode,
  output logic              wwd_strobe,
  output logic [1:0]        wwd_reg,
`ifdef TSC_INST_COUNT_EN
  output logic              illegal,
  output logic [15:0]       num_inst
`else
  output logic              illegal
`endif
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FUNC_W = 6;

  localparam logic [OP_W-1:0]   OP_RTYPE = 4'hF;
  localparam logic [OP_W-1:0]   OP_ADI   = 4'h4;
  localparam logic [OP_W-1:0]   OP_LHI   = 4'h6;
  localparam logic [OP_W-1:0]   OP_JMP   = 4'h9;
  localparam logic [FUNC_W-1:0] FN_ADD   = 6'h00;
  localparam logic [FUNC_W-1:0] FN_WWD   = 6'h1C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_EX,
    S_WB
  } state_t;

  state_t            state;
  logic              req_pending;
  logic [OP_W-1:0]   opcode;
  logic [FUNC_W-1:0] func;
  logic              is_add;
  logic              is_wwd;
  logic              is_adi;
  logic              is_lhi;
  logic              is_jmp;
  logic              is_legal;
  logic              wb_fire;
  logic              fetch_done;

  // Decode is a pure function of the latched instruction word.
  assign opcode   = inst[15:12];
  assign func     = inst[5:0];
  assign is_add   = (opcode == OP_RTYPE) && (func == FN_ADD);
  assign is_wwd   = (opcode == OP_RTYPE) && (func == FN_WWD);
  assign is_adi   = (opcode == OP_ADI);
  assign is_lhi   = (opcode == OP_LHI);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_legal = is_add | is_wwd | is_adi | is_lhi | is_jmp;

  assign rf_waddr = is_add ? inst[7:6] : inst[9:8];
  assign alu_src  = is_adi | is_lhi;
  assign imm_mode = is_adi ? 2'b01 : (is_lhi ? 2'b10 : 2'b00);
  assign wwd_reg  = inst[11:10];

  // A request once raised stays up until acked, regardless of cpu_enable.
  assign mem_req    = (state == S_IF) && (cpu_enable || req_pending) && !RST;
  assign mem_addr   = pc[ADDR_W-1:0];
  assign fetch_done = mem_req && mem_ack;

  // WB side effects happen only in the cycle WB is actually left.
  assign wb_fire    = (state == S_WB) && cpu_enable && !RST;
  assign rf_we      = wb_fire && (is_add || is_adi || is_lhi);
  assign wwd_strobe = wb_fire && is_wwd;
  assign illegal    = wb_fire && !is_legal;

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      inst        <= 16'h0000;
      req_pending <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cpu_enable) state <= S_IF;
        end
        S_IF: begin
          if (fetch_done) begin
            inst        <= mem_rdata;
            req_pending <= 1'b0;
            state       <= S_ID;
          end else if (mem_req) begin
            req_pending <= 1'b1;
          end
        end
        S_ID: begin
          if (cpu_enable) state <= S_EX;
        end
        S_EX: begin
          if (cpu_enable) state <= S_WB;
        end
        S_WB: begin
          if (cpu_enable) begin
            pc    <= is_jmp ? {pc[15:12], inst[11:0]} : pc + 16'd1;
            state <= S_IF;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TSC_INST_COUNT_EN
  // Counts every retired instruction, including JMP and illegal ones.
  always_ff @(posedge clk) begin
    if (RST) begin
      num_inst <= 16'h0000;
    end else if (wb_fire) begin
      num_inst <= num_inst + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tsc_cycle_sequencer.sv
// Bench for tsc_cycle_sequencer: directed vector table, reset-abort sequence,
// then random instructions checked against an instruction-level reference model.
module tb_tsc_cycle_sequencer;

  localparam int unsigned ADDR_W = 6;
  localparam logic [15:0] RST_PC = 16'hFFFE;

  logic              clk = 1'b0;
  logic              RST;
  logic              cpu_enable;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic [15:0]       inst;
  logic [15:0]       pc;
  logic              rf_we;
  logic [1:0]        rf_waddr;
  logic              alu_src;
  logic [1:0]        imm_mode;
  logic              wwd_strobe;
  logic [1:0]        wwd_reg;
  logic              illegal;
`ifdef TSC_INST_COUNT_EN
  logic [15:0]       num_inst;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] exp_cnt = 16'h0000;

  always #5 clk = ~clk;

  tsc_cycle_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .RST        (RST),
    .cpu_enable (cpu_enable),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst       (inst),
    .pc         (pc),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .alu_src    (alu_src),
    .imm_mode   (imm_mode),
    .wwd_strobe (wwd_strobe),
    .wwd_reg    (wwd_reg),
    .illegal    (illegal)
`ifdef TSC_INST_COUNT_EN
    , .num_inst (num_inst)
`endif
  );

  typedef struct {
    logic       rf_we;
    logic [1:0] waddr;
    logic       alu_src;
    logic [1:0] imm;
    logic       wwd;
    logic [1:0] wwd_reg;
    logic       ill;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic [15:0] w;
    int unsigned ack_wait;
    int unsigned ex_hold;
    int unsigned wb_hold;
    int unsigned if_stall;
    bit          drop_en;
    logic [5:0]  addr;
    exp_t        e;
  } vec_t;

  typedef struct {
    bit          got;
    logic [5:0]  addr;
    bit          addr_bad;
    int unsigned nreq;
    int unsigned stall_req;
    int unsigned early;
    logic        rf_we;
    logic [1:0]  waddr;
    logic        alu_src;
    logic [1:0]  imm;
    logic        wwd;
    logic [1:0]  wwd_reg;
    logic        ill;
    logic [15:0] inst;
    logic [15:0] pc;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: what one retired instruction does at a given PC.
  function automatic exp_t model(input logic [15:0] p, input logic [15:0] w);
    exp_t e;
    e = '{rf_we: 1'b0, waddr: 2'd0, alu_src: 1'b0, imm: 2'b00, wwd: 1'b0,
          wwd_reg: w[11:10], ill: 1'b0, pc: p + 16'd1};
    case (w[15:12])
      4'hF: begin
        if (w[5:0] == 6'h00) begin e.rf_we = 1'b1; e.waddr = w[7:6]; end
        else if (w[5:0] == 6'h1C) e.wwd = 1'b1;
        else e.ill = 1'b1;
      end
      4'h4: begin e.rf_we = 1'b1; e.waddr = w[9:8]; e.alu_src = 1'b1; e.imm = 2'b01; end
      4'h6: begin e.rf_we = 1'b1; e.waddr = w[9:8]; e.alu_src = 1'b1; e.imm = 2'b10; end
      4'h9: e.pc = {p[15:12], w[11:0]};
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic tally(inout obs_t o);
    o.early += int'(rf_we) + int'(wwd_strobe) + int'(illegal);
  endtask

  // Walks one instruction through IF/ID/EX/WB, driving at negedge and sampling 1ns later.
  task automatic do_inst(input vec_t v, output obs_t o);
    int unsigned guard = 0;
    int unsigned stall = 0;
    o = '{default: 0};
    while (!o.got && guard < 64) begin
      @(negedge clk);
      guard++;
      if (stall < v.if_stall) begin
        cpu_enable = 1'b0;
        mem_ack = 1'b0;
        stall++;
        #1;
        if (mem_req) o.stall_req++;
        tally(o);
        continue;
      end
      cpu_enable = (v.drop_en && o.nreq > 0) ? 1'b0 : 1'b1;
      #1;
      tally(o);
      if (mem_req) begin
        if (o.nreq == 0) o.addr = mem_addr;
        else if (mem_addr != o.addr) o.addr_bad = 1'b1;
        o.nreq++;
        if (o.nreq > v.ack_wait) begin
          mem_ack = 1'b1; mem_rdata = v.w; o.got = 1'b1;
        end else begin
          mem_ack = 1'b0; mem_rdata = 16'($urandom);
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
    if (!o.got) return;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 16'($urandom); cpu_enable = 1'b1;
    #1; tally(o);
    for (int i = 0; i < int'(v.ex_hold); i++) begin
      @(negedge clk); cpu_enable = 1'b0; #1; tally(o);
    end
    @(negedge clk); cpu_enable = 1'b1; #1; tally(o);
    for (int i = 0; i < int'(v.wb_hold); i++) begin
      @(negedge clk); cpu_enable = 1'b0; #1; tally(o);
    end
    @(negedge clk); cpu_enable = 1'b1; #1;
    o.rf_we = rf_we; o.waddr = rf_waddr; o.alu_src = alu_src; o.imm = imm_mode;
    o.wwd = wwd_strobe; o.wwd_reg = wwd_reg; o.ill = illegal; o.inst = inst;
    @(posedge clk); #1;
    o.pc = pc;
  endtask

  task automatic apply(input vec_t v);
    obs_t o;
    do_inst(v, o);
    chk("fetch_done", 32'(o.got), 32'd1);
    if (!o.got) return;
    chk("mem_addr", 32'(o.addr), 32'(v.addr));
    chk("addr_stable", 32'(o.addr_bad), 32'd0);
    chk("req_cycles", o.nreq, v.ack_wait + 1);
    chk("req_while_stalled", o.stall_req, 32'd0);
    chk("stray_strobe", o.early, 32'd0);
    chk("inst", 32'(o.inst), 32'(v.w));
    chk("rf_we", 32'(o.rf_we), 32'(v.e.rf_we));
    if (v.e.rf_we) chk("rf_waddr", 32'(o.waddr), 32'(v.e.waddr));
    chk("alu_src", 32'(o.alu_src), 32'(v.e.alu_src));
    chk("imm_mode", 32'(o.imm), 32'(v.e.imm));
    chk("wwd_strobe", 32'(o.wwd), 32'(v.e.wwd));
    chk("wwd_reg", 32'(o.wwd_reg), 32'(v.e.wwd_reg));
    chk("illegal", 32'(o.ill), 32'(v.e.ill));
    chk("pc", 32'(o.pc), 32'(v.e.pc));
    exp_cnt = exp_cnt + 16'd1;
`ifdef TSC_INST_COUNT_EN
    chk("num_inst", 32'(num_inst), 32'(exp_cnt));
`endif
  endtask

  vec_t tbl[9];

  initial begin
    vec_t  v;
    logic [15:0] mpc;
    logic [15:0] r;

    // Directed table; PC starts at FFFE so the wrap and JMP page-keep are exercised.
    //           inst      ack ex  wb  ifs drop addr   rf_we waddr alu imm  wwd  wreg ill  pc
    tbl[0] = '{16'h6101, 0, 0, 0, 0, 0, 6'h3E, '{1'b1, 2'd1, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 16'hFFFF}};
    tbl[1] = '{16'hF6C0, 0, 0, 0, 0, 0, 6'h3F, '{1'b1, 2'd3, 1'b0, 2'b00, 1'b0, 2'd1, 1'b0, 16'h0000}};
    tbl[2] = '{16'h9010, 0, 0, 0, 0, 0, 6'h00, '{1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 16'h0010}};
    tbl[3] = '{16'h9015, 0, 0, 0, 0, 0, 6'h10, '{1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 16'h0015}};
    tbl[4] = '{16'hF81C, 0, 0, 0, 0, 0, 6'h15, '{1'b0, 2'd0, 1'b0, 2'b00, 1'b1, 2'd2, 1'b0, 16'h0016}};
    tbl[5] = '{16'h2000, 0, 0, 0, 0, 0, 6'h16, '{1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 16'h0017}};
    tbl[6] = '{16'h4BFF, 3, 2, 0, 0, 1, 6'h17, '{1'b1, 2'd3, 1'b1, 2'b01, 1'b0, 2'd2, 1'b0, 16'h0018}};
    tbl[7] = '{16'hF03F, 1, 0, 2, 0, 0, 6'h18, '{1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 16'h0019}};
    tbl[8] = '{16'h600A, 0, 1, 1, 2, 0, 6'h19, '{1'b1, 2'd0, 1'b1, 2'b10, 1'b0, 2'd0, 1'b0, 16'h001A}};

    RST = 1'b1; cpu_enable = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_pc", 32'(pc), 32'(RST_PC));
    chk("reset_inst", 32'(inst), 32'd0);
    chk("reset_strobes", 32'({rf_we, wwd_strobe, illegal, alu_src, imm_mode}), 32'd0);
`ifdef TSC_INST_COUNT_EN
    chk("reset_num_inst", 32'(num_inst), 32'd0);
`endif
    @(negedge clk); RST = 1'b0;
    @(negedge clk); #1;
    chk("idle_no_req", 32'(mem_req), 32'd0);

    foreach (tbl[i]) apply(tbl[i]);

    // Reset in EX of an ADI: the write must never appear and the fetch restarts from RESET_PC.
    @(negedge clk); cpu_enable = 1'b1; #1;
    chk("abort_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 16'h4A55;
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("abort_id_we", 32'(rf_we), 32'd0);
    @(negedge clk); RST = 1'b1; #1;
    chk("abort_ex_we", 32'(rf_we), 32'd0);
    @(negedge clk); RST = 1'b0; #1;
    chk("abort_idle_req", 32'(mem_req), 32'd0);
    chk("abort_idle_we", 32'(rf_we), 32'd0);
    chk("abort_pc", 32'(pc), 32'(RST_PC));
    chk("abort_inst", 32'(inst), 32'd0);
    exp_cnt = 16'h0000;
`ifdef TSC_INST_COUNT_EN
    chk("abort_num_inst", 32'(num_inst), 32'd0);
`endif

    mpc = RST_PC;
    for (int i = 0; i < 40; i++) begin
      r = 16'($urandom);
      case (i == 0 ? 3 : (i == 1 ? 8 : int'($urandom_range(0, 7))))
        0: v.w = {4'hF, r[11:6], 6'h00};
        1: v.w = {4'hF, r[11:6], 6'h1C};
        2: v.w = {4'h4, r[11:0]};
        3: v.w = {4'h6, r[11:0]};
        4: v.w = {4'h9, r[11:0]};
        5: v.w = {4'hF, r[11:0]};
        6: v.w = r;
        7: v.w = {4'($urandom_range(0, 3)), r[11:0]};
        default: v.w = 16'h9ABC;
      endcase
      v.ack_wait = $urandom_range(0, 3);
      v.ex_hold  = $urandom_range(0, 2);
      v.wb_hold  = $urandom_range(0, 1);
      v.if_stall = $urandom_range(0, 1);
      v.drop_en  = 1'($urandom_range(0, 1));
      v.addr     = mpc[5:0];
      v.e        = model(mpc, v.w);
      apply(v);
      mpc = v.e.pc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
